// File: rtl/iq_free_list_ctrl_pkg.sv
// Shared issue-queue definitions.
// Holds the IQ geometry, derived widths used by dispatch/rename, the freed-entry
// packet carried on the IQ free path, and a wrapping pointer helper.
package iq_free_list_ctrl_pkg;

   localparam int unsigned SIZE_ISSUEQ    = 32;
   localparam int unsigned ISSUE_WIDTH    = 4;
   localparam int unsigned DISPATCH_WIDTH = 4;

   localparam int unsigned IQ_ID_W       = $clog2(SIZE_ISSUEQ);
   localparam int unsigned IQ_CNT_W      = $clog2(SIZE_ISSUEQ) + 1;
   localparam int unsigned IQ_REQ_W      = $clog2(DISPATCH_WIDTH) + 1;
   localparam int unsigned IQ_LANE_CNT_W = $clog2(ISSUE_WIDTH) + 1;

   typedef logic [IQ_ID_W-1:0] iq_id_t;

   typedef struct packed {
      logic   valid;
      iq_id_t id;
   } iqEntryPkt;

   // Pointer arithmetic wraps naturally because pointers are exactly IQ_ID_W bits.
   function automatic iq_id_t iq_ptr_add(iq_id_t ptr, int unsigned off);
      return ptr + IQ_ID_W'(off);
   endfunction

endpackage

// File: rtl/iq_free_list_ctrl_if.sv
// Dispatch/free-path bundle of the IQ free list.
//   allocValid/allocCnt : dispatch request (master -> slave)
//   allocGrant/allocId  : all-or-nothing grant and lane-ordered IDs (slave -> master)
//   freedEntry          : returned entries {valid,id} per issue lane (master -> slave)
interface iq_free_list_ctrl_if;
   import iq_free_list_ctrl_pkg::*;

   logic                               allocValid;
   logic [IQ_REQ_W-1:0]                allocCnt;
   logic                               allocGrant;
   iq_id_t [DISPATCH_WIDTH-1:0]        allocId;
   iqEntryPkt [ISSUE_WIDTH-1:0]        freedEntry;

   modport master (
      output allocValid, allocCnt, freedEntry,
      input  allocGrant, allocId
   );

   modport slave (
      input  allocValid, allocCnt, freedEntry,
      output allocGrant, allocId
   );

endinterface

// File: rtl/iq_free_list_ctrl_free_lane_compactor.sv
// free_lane_compactor: packs the valid lanes of a freed-entry vector into the
// low lanes in ascending lane order and reports how many were valid.
//   entry_i  : per-lane {valid,id}
//   id_o     : compacted IDs; lanes >= n_free_o are zero
//   n_free_o : number of valid input lanes
// Purely combinational.
module free_lane_compactor
   import iq_free_list_ctrl_pkg::*;
#(
   parameter int unsigned Lanes = ISSUE_WIDTH
) (
   input  iqEntryPkt [Lanes-1:0]  entry_i,
   output iq_id_t [Lanes-1:0]     id_o,
   output logic [$clog2(Lanes):0] n_free_o
);

   localparam int unsigned IdxW = (Lanes > 1) ? $clog2(Lanes) : 1;

   logic [$clog2(Lanes):0] prefix;

   // Running prefix count of valid bits is the destination slot of each valid lane.
   always_comb begin
      id_o   = '0;
      prefix = '0;
      for (int unsigned i = 0; i < Lanes; i++) begin
         if (entry_i[i].valid) begin
            id_o[prefix[IdxW-1:0]] = entry_i[i].id;
            prefix                 = prefix + 1'b1;
         end
      end
      n_free_o = prefix;
   end

endmodule

// File: rtl/iq_free_list_ctrl.sv
// iq_free_list_ctrl: circular free list of issue-queue entry IDs.
//   clk, reset    : clock; synchronous active-low reset
//   flush_i       : reinitialise list to all-free (overflow error kept)
//   alloc_if      : slave side of dispatch alloc / freed-entry bundle
//   freeCnt_o     : registered number of free entries
//   iqStall_o     : fewer than DISPATCH_WIDTH entries free
//   overflowErr_o : sticky, set when returned entries would exceed the list depth
module iq_free_list_ctrl
   import iq_free_list_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                flush_i,
   iq_free_list_ctrl_if.slave  alloc_if,
   output logic [IQ_CNT_W-1:0] freeCnt_o,
   output logic                iqStall_o,
   output logic                overflowErr_o
);

   iq_id_t              id_list_q [SIZE_ISSUEQ];
   iq_id_t              id_list_d [SIZE_ISSUEQ];
   iq_id_t              head_q, head_d;
   iq_id_t              tail_q, tail_d;
   logic [IQ_CNT_W-1:0] free_cnt_q, free_cnt_d;
   logic                overflow_err_q, overflow_err_d;

   iq_id_t [ISSUE_WIDTH-1:0]  comp_id;
   logic [IQ_LANE_CNT_W-1:0]  n_free;

   logic [IQ_CNT_W-1:0] req_cnt, granted, room, n_free_ext, n_accept;
   logic                cnt_legal, grant, overflow, dup_free;

   free_lane_compactor #(
      .Lanes (ISSUE_WIDTH)
   ) u_compactor (
      .entry_i  (alloc_if.freedEntry),
      .id_o     (comp_id),
      .n_free_o (n_free)
   );

   // Grant and overflow clamp, both based on the pre-update count.
   always_comb begin
      req_cnt    = IQ_CNT_W'(alloc_if.allocCnt);
      cnt_legal  = (req_cnt <= IQ_CNT_W'(DISPATCH_WIDTH));
      grant      = alloc_if.allocValid & ~flush_i & cnt_legal & (req_cnt != '0)
                   & (req_cnt <= free_cnt_q);
      granted    = grant ? req_cnt : '0;
      room       = IQ_CNT_W'(SIZE_ISSUEQ) - (free_cnt_q - granted);
      n_free_ext = IQ_CNT_W'(n_free);
      overflow   = (n_free_ext > room);
      // Excess frees are the highest compacted lanes; keep only what fits.
      n_accept   = overflow ? room : n_free_ext;
   end

   // Zero-latency read from the head slots; freed IDs land at tail, so no bypass.
   always_comb begin
      alloc_if.allocGrant = grant;
      for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
         alloc_if.allocId[k] = id_list_q[iq_ptr_add(head_q, k)];
      end
   end

   always_comb begin
      id_list_d      = id_list_q;
      head_d         = head_q;
      tail_d         = tail_q;
      free_cnt_d     = free_cnt_q;
      overflow_err_d = overflow_err_q;
      if (flush_i) begin
         for (int unsigned i = 0; i < SIZE_ISSUEQ; i++) begin
            id_list_d[i] = IQ_ID_W'(i);
         end
         head_d     = '0;
         tail_d     = '0;
         free_cnt_d = IQ_CNT_W'(SIZE_ISSUEQ);
      end else begin
         for (int unsigned m = 0; m < ISSUE_WIDTH; m++) begin
            if (IQ_CNT_W'(m) < n_accept) begin
               id_list_d[iq_ptr_add(tail_q, m)] = comp_id[m];
            end
         end
         head_d         = head_q + IQ_ID_W'(granted);
         tail_d         = tail_q + IQ_ID_W'(n_accept);
         free_cnt_d     = free_cnt_q - granted + n_accept;
         overflow_err_d = overflow_err_q | overflow;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < SIZE_ISSUEQ; i++) begin
            id_list_q[i] <= IQ_ID_W'(i);
         end
         head_q         <= '0;
         tail_q         <= '0;
         free_cnt_q     <= IQ_CNT_W'(SIZE_ISSUEQ);
         overflow_err_q <= 1'b0;
      end else begin
         id_list_q      <= id_list_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         free_cnt_q     <= free_cnt_d;
         overflow_err_q <= overflow_err_d;
      end
   end

   assign freeCnt_o     = free_cnt_q;
   assign iqStall_o     = (free_cnt_q < IQ_CNT_W'(DISPATCH_WIDTH));
   assign overflowErr_o = overflow_err_q;

   // Same ID returned on two lanes in one cycle is a caller bug.
   always_comb begin
      dup_free = 1'b0;
      for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
         for (int unsigned j = i + 1; j < ISSUE_WIDTH; j++) begin
            if (alloc_if.freedEntry[i].valid && alloc_if.freedEntry[j].valid &&
                (alloc_if.freedEntry[i].id == alloc_if.freedEntry[j].id)) begin
               dup_free = 1'b1;
            end
         end
      end
   end

   a_no_dup_free: assert property (@(posedge clk) disable iff (!reset)
      !(dup_free && !flush_i))
      else $error("duplicate IQ id returned in one cycle");

   a_alloc_cnt_legal: assert property (@(posedge clk) disable iff (!reset)
      !(alloc_if.allocValid && !cnt_legal))
      else $error("allocCnt above dispatch width");

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(overflow && !flush_i))
      else $warning("IQ free list overflow, excess returned entries dropped");

endmodule

// File: tb/tb_iq_free_list_ctrl.sv
module tb_iq_free_list_ctrl;
   import iq_free_list_ctrl_pkg::*;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                flush = 1'b0;
   logic [IQ_CNT_W-1:0] free_cnt;
   logic                iq_stall;
   logic                overflow_err;

   iq_free_list_ctrl_if bus ();

   iq_free_list_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .flush_i       (flush),
      .alloc_if      (bus),
      .freeCnt_o     (free_cnt),
      .iqStall_o     (iq_stall),
      .overflowErr_o (overflow_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic            grant;
      logic [2:0]      n;
      logic [3:0][4:0] ids;
      logic [5:0]      cnt_after;
      logic            stall_after;
      logic            err_after;
   } exp_t;

   exp_t sb_q[$];
   int   model_q[$];   // free IDs in allocation order
   int   in_use[$];    // IDs granted and not yet returned, oldest first
   bit   model_err;
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic model_init(input bit clear_err);
      model_q.delete();
      for (int i = 0; i < 32; i++) model_q.push_back(i);
      if (clear_err) model_err = 1'b0;
   endtask

   task automatic bus_idle();
      bus.allocValid = 1'b0;
      bus.allocCnt   = '0;
      bus.freedEntry = '0;
      flush          = 1'b0;
   endtask

   // Drive one cycle of stimulus and push the model's expectation.
   task automatic drive(input bit av, input int cnt, input logic [3:0] mask,
                        input logic [3:0][4:0] ids, input bit fl);
      exp_t e;
      @(negedge clk);
      bus.allocValid = av;
      bus.allocCnt   = IQ_REQ_W'(cnt);
      flush          = fl;
      for (int l = 0; l < 4; l++) begin
         bus.freedEntry[l].valid = mask[l];
         bus.freedEntry[l].id    = ids[l];
      end
      e       = '0;
      e.grant = av && !fl && cnt > 0 && cnt <= 4 && cnt <= model_q.size();
      e.n     = 3'(cnt);
      for (int k = 0; k < 4; k++) e.ids[k] = (k < model_q.size()) ? 5'(model_q[k]) : 5'd0;
      if (fl) begin
         model_init(1'b0);
      end else begin
         if (e.grant) repeat (cnt) in_use.push_back(model_q.pop_front());
         for (int l = 0; l < 4; l++) begin
            if (mask[l]) begin
               if (model_q.size() < 32) model_q.push_back(int'(ids[l]));
               else model_err = 1'b1;
            end
         end
      end
      e.cnt_after   = 6'(model_q.size());
      e.stall_after = (model_q.size() < 4);
      e.err_after   = model_err;
      sb_q.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus_idle();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      model_init(1'b1);
      in_use.delete();
      sb_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_checks++;
      if (free_cnt !== 6'd32) begin
         n_fail++; $display("FAIL reset_free_cnt: got %0d expected 32", free_cnt);
      end
      n_checks++;
      if (iq_stall !== 1'b0) begin
         n_fail++; $display("FAIL reset_stall: got %b expected 0", iq_stall);
      end
      n_checks++;
      if (overflow_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow_err);
      end
   endtask

   task automatic test_single_alloc();
      exp_t e;
      drive(1, 4, 4'b0000, '0, 0);
      #1;
      e = sb_q.pop_front();
      n_checks++;
      if (bus.allocGrant !== 1'b1) begin
         n_fail++; $display("FAIL first_grant: got %b expected 1", bus.allocGrant);
      end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (bus.allocId[k] !== 5'(k)) begin
            n_fail++; $display("FAIL first_id[%0d]: got %0d expected %0d", k, bus.allocId[k], k);
         end
      end
      @(posedge clk); #1;
      n_checks++;
      if (free_cnt !== 6'd28 || free_cnt !== e.cnt_after) begin
         n_fail++; $display("FAIL first_free_cnt: got %0d expected 28", free_cnt);
      end
   endtask

   task automatic test_drain();
      exp_t e;
      for (int c = 0; c < 7; c++) begin
         drive(1, 4, 4'b0000, '0, 0);
         #1;
         e = sb_q.pop_front();
         n_checks++;
         if (bus.allocGrant !== e.grant) begin
            n_fail++; $display("FAIL drain_grant: got %b expected %b", bus.allocGrant, e.grant);
         end
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (bus.allocId[k] !== e.ids[k]) begin
               n_fail++;
               $display("FAIL drain_id[%0d]: got %0d expected %0d", k, bus.allocId[k], e.ids[k]);
            end
         end
         @(posedge clk); #1;
         n_checks++;
         if (free_cnt !== e.cnt_after) begin
            n_fail++; $display("FAIL drain_cnt: got %0d expected %0d", free_cnt, e.cnt_after);
         end
      end
      n_checks++;
      if (free_cnt !== 6'd0 || iq_stall !== 1'b1) begin
         n_fail++; $display("FAIL drained_state: got cnt %0d stall %b expected 0/1",
                            free_cnt, iq_stall);
      end
      drive(1, 1, 4'b0000, '0, 0);
      #1;
      e = sb_q.pop_front();
      n_checks++;
      if (bus.allocGrant !== 1'b0 || bus.allocGrant !== e.grant) begin
         n_fail++; $display("FAIL empty_grant: got %b expected 0", bus.allocGrant);
      end
      @(posedge clk); #1;
      n_checks++;
      if (free_cnt !== 6'd0) begin
         n_fail++; $display("FAIL empty_cnt: got %0d expected 0", free_cnt);
      end
   endtask

   task automatic test_sparse_free();
      exp_t e;
      drive(0, 0, 4'b1010, {5'd5, 5'd17, 5'd9, 5'd31}, 0);
      #1;
      e = sb_q.pop_front();
      @(posedge clk); #1;
      n_checks++;
      if (free_cnt !== 6'd2 || free_cnt !== e.cnt_after || iq_stall !== 1'b1) begin
         n_fail++; $display("FAIL sparse_cnt: got cnt %0d stall %b expected 2/1",
                            free_cnt, iq_stall);
      end
      drive(1, 2, 4'b0000, '0, 0);
      #1;
      e = sb_q.pop_front();
      n_checks++;
      if (bus.allocGrant !== 1'b1 || bus.allocId[0] !== 5'd9 || bus.allocId[1] !== 5'd5) begin
         n_fail++; $display("FAIL sparse_ids: got grant %b ids %0d,%0d expected 1 9,5",
                            bus.allocGrant, bus.allocId[0], bus.allocId[1]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (free_cnt !== e.cnt_after) begin
         n_fail++; $display("FAIL sparse_alloc_cnt: got %0d expected %0d", free_cnt, e.cnt_after);
      end
   endtask

   task automatic test_alloc_and_free();
      exp_t e;
      drive(0, 0, 4'b0111, {5'd0, 5'd22, 5'd21, 5'd20}, 0);
      #1;
      e = sb_q.pop_front();
      @(posedge clk); #1;
      n_checks++;
      if (free_cnt !== 6'd3) begin
         n_fail++; $display("FAIL af_pre_cnt: got %0d expected 3", free_cnt);
      end
      drive(1, 3, 4'b1111, {5'd3, 5'd2, 5'd1, 5'd0}, 0);
      #1;
      e = sb_q.pop_front();
      n_checks++;
      if (bus.allocGrant !== 1'b1 || bus.allocId[0] !== 5'd20 || bus.allocId[1] !== 5'd21 ||
          bus.allocId[2] !== 5'd22) begin
         n_fail++; $display("FAIL af_grant_ids: got %b %0d,%0d,%0d expected 1 20,21,22",
                            bus.allocGrant, bus.allocId[0], bus.allocId[1], bus.allocId[2]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (free_cnt !== 6'd4 || free_cnt !== e.cnt_after) begin
         n_fail++; $display("FAIL af_cnt: got %0d expected 4", free_cnt);
      end
      drive(1, 4, 4'b0000, '0, 0);
      #1;
      e = sb_q.pop_front();
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (bus.allocId[k] !== 5'(k) || bus.allocId[k] !== e.ids[k]) begin
            n_fail++; $display("FAIL af_freed_id[%0d]: got %0d expected %0d", k, bus.allocId[k], k);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_wrap();
      exp_t            e;
      logic [3:0]      mask;
      logic [3:0][4:0] fids;
      do_reset();
      for (int c = 0; c < 20; c++) begin
         mask = 4'b0000;
         fids = '0;
         if (in_use.size() >= 4) begin
            mask = 4'b1111;
            for (int l = 0; l < 4; l++) fids[l] = 5'(in_use.pop_front());
         end
         drive(1, 4, mask, fids, 0);
         #1;
         e = sb_q.pop_front();
         n_checks++;
         if (bus.allocGrant !== e.grant) begin
            n_fail++; $display("FAIL wrap_grant[%0d]: got %b expected %b", c, bus.allocGrant, e.grant);
         end
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (bus.allocId[k] !== e.ids[k]) begin
               n_fail++;
               $display("FAIL wrap_id[%0d][%0d]: got %0d expected %0d", c, k, bus.allocId[k],
                        e.ids[k]);
            end
         end
         @(posedge clk); #1;
         n_checks++;
         if (free_cnt !== 6'd28 || free_cnt !== e.cnt_after) begin
            n_fail++; $display("FAIL wrap_cnt[%0d]: got %0d expected 28", c, free_cnt);
         end
      end
   endtask

   task automatic test_overflow();
      exp_t            e;
      logic [3:0][4:0] fids;
      for (int l = 0; l < 4; l++) fids[l] = 5'(in_use.pop_front());
      drive(0, 0, 4'b1111, fids, 0);
      #1; e = sb_q.pop_front();
      @(posedge clk); #1;
      n_checks++;
      if (free_cnt !== 6'd32 || overflow_err !== 1'b0) begin
         n_fail++; $display("FAIL full_state: got cnt %0d err %b expected 32/0",
                            free_cnt, overflow_err);
      end
      drive(0, 0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd7}, 0);
      #1; e = sb_q.pop_front();
      @(posedge clk); #1;
      n_checks++;
      if (overflow_err !== 1'b1 || overflow_err !== e.err_after || free_cnt !== 6'd32) begin
         n_fail++; $display("FAIL overflow_set: got err %b cnt %0d expected 1/32",
                            overflow_err, free_cnt);
      end
      drive(0, 0, 4'b0000, '0, 0);
      #1; e = sb_q.pop_front();
      @(posedge clk); #1;
      n_checks++;
      if (overflow_err !== 1'b1) begin
         n_fail++; $display("FAIL overflow_sticky: got %b expected 1", overflow_err);
      end
      drive(1, 4, 4'b0000, '0, 1);
      #1; e = sb_q.pop_front();
      n_checks++;
      if (bus.allocGrant !== 1'b0) begin
         n_fail++; $display("FAIL flush_grant: got %b expected 0", bus.allocGrant);
      end
      @(posedge clk); #1;
      n_checks++;
      if (overflow_err !== 1'b1 || free_cnt !== e.cnt_after) begin
         n_fail++; $display("FAIL flush_keeps_err: got err %b cnt %0d expected 1/32",
                            overflow_err, free_cnt);
      end
      do_reset();
      #1;
      n_checks++;
      if (overflow_err !== 1'b0 || free_cnt !== 6'd32) begin
         n_fail++; $display("FAIL reset_clears_err: got err %b cnt %0d expected 0/32",
                            overflow_err, free_cnt);
      end
      for (int c = 0; c < 8; c++) begin
         drive(1, 4, 4'b0000, '0, 0);
         #1; e = sb_q.pop_front();
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (bus.allocId[k] !== 5'(4 * c + k)) begin
               n_fail++; $display("FAIL restored_id[%0d]: got %0d expected %0d", 4 * c + k,
                                  bus.allocId[k], 4 * c + k);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      bus_idle();
      model_init(1'b1);
      test_reset();
      test_single_alloc();
      test_drain();
      test_sparse_free();
      test_alloc_and_free();
      test_wrap();
      test_overflow();
      @(negedge clk);
      bus_idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
